serial_adder_controller: RTL

Bit-serial adder that sequences a single one-bit full-adder cell across a DATA_WIDTH-bit operand pair, one bit per clock, LSB first. It sits in the arithmetic library as the low-area alternative to a ripple-carry adder. Requesters issue a one-cycle start with both operands and a carry-in. The block reports a one-cycle done together with the held sum and carry-out.

---
 rtl/serial_adder_controller_if.sv | 60 ++++++
 rtl/serial_adder_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder_controller_if.sv
// rtl/serial_adder_controller_if.sv - request/response bundle for the bit-serial adder
//
// Purpose : groups the start/operand request and the busy/done/result response
//           of serial_adder_controller into one interface.
// Macro   : SERIAL_ADDER_SUB_EN adds the Sub_In request signal.
// Signals :
//   Start_In   requester -> adder  one-cycle start request
//   Data_A_In  requester -> adder  operand A (DATA_WIDTH bits)
//   Data_B_In  requester -> adder  operand B (DATA_WIDTH bits)
//   Carry_In   requester -> adder  carry into bit 0
//   Sub_In     requester -> adder  1 selects A minus B (SERIAL_ADDER_SUB_EN only)
//   Busy_Out   adder -> requester  high while RUN or DONE
//   Done_Out   adder -> requester  one-cycle completion pulse
//   Sum_Out    adder -> requester  last completed sum (DATA_WIDTH bits)
//   Carry_Out  adder -> requester  last completed carry out of the MSB
// Modports: master (requester side), slave (adder side).

interface serial_adder_controller_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Start_In;
    logic [DATA_WIDTH-1:0] Data_A_In;
    logic [DATA_WIDTH-1:0] Data_B_In;
    logic                  Carry_In;
`ifdef SERIAL_ADDER_SUB_EN
    logic                  Sub_In;
`endif
    logic                  Busy_Out;
    logic                  Done_Out;
    logic [DATA_WIDTH-1:0] Sum_Out;
    logic                  Carry_Out;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output Sub_In,
`endif
        output Start_In,
        output Data_A_In,
        output Data_B_In,
        output Carry_In,
        input  Busy_Out,
        input  Done_Out,
        input  Sum_Out,
        input  Carry_Out
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  Sub_In,
`endif
        input  Start_In,
        input  Data_A_In,
        input  Data_B_In,
        input  Carry_In,
        output Busy_Out,
        output Done_Out,
        output Sum_Out,
        output Carry_Out
    );
endinterface

// File: rtl/serial_adder_controller.sv
// rtl/serial_adder_controller.sv - bit-serial adder sequencing one full-adder cell LSB first
//
// Purpose : adds two DATA_WIDTH-bit operands plus a carry-in one bit per clock
//           using a single one-bit full-adder cell. FSM: IDLE -> RUN (DATA_WIDTH
//           cycles) -> DONE (one cycle) -> IDLE.
// Macro   : SERIAL_ADDER_SUB_EN enables Sub_In (A minus B via ~B and carry-in 1).
// Ports   :
//   Clock_In  input   single clock, rising edge
//   Reset_In  input   asynchronous, active-high reset
//   bus       slave   serial_adder_controller_if (start/operands in, busy/done/result out)
// Modules : serial_adder_full_adder (one-bit cell), serial_adder_controller (top).

module serial_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_controller #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      Clock_In,
    input  logic                      Reset_In,
    serial_adder_controller_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] a_shift;
    logic [DATA_WIDTH-1:0] b_shift;
    logic [DATA_WIDTH-1:0] result_shift;
    logic [DATA_WIDTH-1:0] result_next;
    logic                  carry_q;
    logic [CNT_W-1:0]      bit_count;
    logic                  last_bit;

    logic                  fa_sum;
    logic                  fa_cout;

    logic [DATA_WIDTH-1:0] b_load;
    logic                  carry_load;

    // Subtraction is A + ~B + 1; the carry-in request is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = bus.Sub_In ? ~bus.Data_B_In : bus.Data_B_In;
    assign carry_load = bus.Sub_In ? 1'b1 : bus.Carry_In;
`else
    assign b_load     = bus.Data_B_In;
    assign carry_load = bus.Carry_In;
`endif

    serial_adder_full_adder u_cell (
        .a    (a_shift[0]),
        .b    (b_shift[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // The counter holds the index of the bit being processed this cycle.
    assign last_bit = (bit_count == LAST_COUNT);

    // Sum bit enters at the MSB so after DATA_WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        result_next                 = result_shift >> 1;
        result_next[DATA_WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.Start_In) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Busy/Done are registered copies of the next state so no input reaches
    // an output combinationally.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            bus.Busy_Out <= 1'b0;
            bus.Done_Out <= 1'b0;
        end else begin
            bus.Busy_Out <= (state_next != ST_IDLE);
            bus.Done_Out <= (state_next == ST_DONE);
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            a_shift       <= '0;
            b_shift       <= '0;
            result_shift  <= '0;
            carry_q       <= 1'b0;
            bit_count     <= '0;
            bus.Sum_Out   <= '0;
            bus.Carry_Out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Start_In) begin
                        a_shift   <= bus.Data_A_In;
                        b_shift   <= b_load;
                        carry_q   <= carry_load;
                        bit_count <= '0;
                    end
                end
                ST_RUN: begin
                    a_shift      <= a_shift >> 1;
                    b_shift      <= b_shift >> 1;
                    result_shift <= result_next;
                    carry_q      <= fa_cout;
                    bit_count    <= bit_count + CNT_W'(1);
                    // Published only here so partial shift state never shows.
                    if (last_bit) begin
                        bus.Sum_Out   <= result_next;
                        bus.Carry_Out <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
